// File: rtl/serial_mofn_checker.sv
// Serial M-of-N codeword checker: frames qualified bits into N-bit words, flags words without exactly M ones.
// Optional MOFN_SOF_SYNC_EN: frame alignment on sof (IDLE until first sof, sof mid-word restarts the word).
module serial_mofn_checker #(
    parameter int N     = 5,
    parameter int M     = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetH,
    input  logic             din_valid,
    input  logic             din,
    input  logic             sof,
    input  logic             clr_count,
    output logic             word_done,
    output logic             valid,
    output logic             err,
    output logic [N-1:0]     word_out,
    output logic [CNT_W-1:0] err_count
);

    localparam int OW = $clog2(N + 1);
    localparam int BW = $clog2(N);
    localparam logic [BW-1:0]    LAST_IDX = BW'(N - 1);
    localparam logic [OW-1:0]    M_CNT    = OW'(M);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    if (N < 2 || M < 0 || M > N) begin : g_param_err
        $error("serial_mofn_checker: illegal parameters N=%0d M=%0d", N, M);
    end

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BW-1:0]     r_bidx;
    logic [OW-1:0]     r_ones;
    logic [N-2:0]      r_sreg;
    logic              r_word_done;
    logic              r_valid;
    logic              r_err;
    logic [N-1:0]      r_word_out;
    logic [CNT_W-1:0]  r_err_count;

    logic              w_restart;
    logic              w_accept;
    logic              w_last;
    logic              w_match;
    logic [BW-1:0]     w_bidx_eff;
    logic [OW-1:0]     w_ones_eff;
    logic [OW-1:0]     w_total;
    logic [N-1:0]      w_shift;

`ifdef MOFN_SOF_SYNC_EN
    localparam state_t RESET_STATE = IDLE;
    assign w_restart = din_valid & sof;
`else
    localparam state_t RESET_STATE = ACTIVE;
    logic w_unused_sof;
    assign w_unused_sof = sof;
    assign w_restart    = 1'b0;
`endif

    // A restarting bit is always bit 0 of a fresh word, whatever the partial state says.
    assign w_accept   = din_valid & ((r_state == ACTIVE) | w_restart);
    assign w_bidx_eff = w_restart ? '0 : r_bidx;
    assign w_ones_eff = w_restart ? '0 : r_ones;
    assign w_last     = w_accept & (w_bidx_eff == LAST_IDX);
    assign w_total    = w_ones_eff + OW'(din);
    assign w_match    = (w_total == M_CNT);
    assign w_shift    = {r_sreg, din};

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == IDLE && w_restart)
            w_state_nxt = ACTIVE;
    end

    always_ff @(posedge clk or posedge resetH) begin
        if (resetH)
            r_state <= RESET_STATE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge resetH) begin
        if (resetH) begin
            r_bidx <= '0;
            r_ones <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_bidx <= '0;
                r_ones <= '0;
            end else begin
                r_bidx <= w_bidx_eff + BW'(1);
                r_ones <= w_total;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept)
            r_sreg <= w_shift[N-2:0];
    end

    always_ff @(posedge clk or posedge resetH) begin
        if (resetH) begin
            r_word_done <= 1'b0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_word_out  <= '0;
        end else begin
            r_word_done <= w_last;
            r_valid     <= w_last & w_match;
            r_err       <= w_last & ~w_match;
            if (w_last)
                r_word_out <= w_shift;
        end
    end

    // Counted at the same edge the err pulse is registered, so a coinciding clear wins.
    always_ff @(posedge clk or posedge resetH) begin
        if (resetH)
            r_err_count <= '0;
        else if (clr_count)
            r_err_count <= '0;
        else if (w_last && !w_match && r_err_count != CNT_MAX)
            r_err_count <= r_err_count + CNT_W'(1);
    end

    assign word_done = r_word_done;
    assign valid     = r_valid;
    assign err       = r_err;
    assign word_out  = r_word_out;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_serial_mofn_checker.sv
// Testbench for serial_mofn_checker: table vectors, hand sequences and a queue-based reference model.
module tb_serial_mofn_checker;

    localparam int N = 5;
    localparam int M = 3;

    logic       clk = 1'b0;
    logic       resetH = 1'b1;
    logic       din_valid = 1'b0;
    logic       din = 1'b0;
    logic       sof = 1'b0;
    logic       clr_count = 1'b0;

    logic       word_done, valid, err;
    logic [4:0] word_out;
    logic [7:0] err_count;
    logic       s_word_done, s_valid, s_err;
    logic [4:0] s_word_out;
    logic [1:0] s_err_count;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    serial_mofn_checker #(.N(N), .M(M), .CNT_W(8)) dut (
        .clk(clk), .resetH(resetH), .din_valid(din_valid), .din(din), .sof(sof),
        .clr_count(clr_count), .word_done(word_done), .valid(valid), .err(err),
        .word_out(word_out), .err_count(err_count));

    serial_mofn_checker #(.N(N), .M(M), .CNT_W(2)) dut_sat (
        .clk(clk), .resetH(resetH), .din_valid(din_valid), .din(din), .sof(sof),
        .clr_count(clr_count), .word_done(s_word_done), .valid(s_valid), .err(s_err),
        .word_out(s_word_out), .err_count(s_err_count));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_err);
        $fatal(1, "watchdog");
    end

    // Reference model: accepted bits queue up; a full queue is one word, judged by popcount.
    bit         mq[$];
    bit         m_started;
    logic       m_done, m_valid, m_err;
    logic [4:0] m_word;
    int         m_cnt8, m_cnt2;

    function automatic bit started_after_reset();
`ifdef MOFN_SOF_SYNC_EN
        return 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        m_started = started_after_reset();
        m_done = 0; m_valid = 0; m_err = 0; m_word = '0;
        m_cnt8 = 0; m_cnt2 = 0;
    endtask

    task automatic model_edge(input logic dv, input logic d, input logic s, input logic clr);
        int ones;
        m_done = 0; m_valid = 0; m_err = 0;
        if (dv) begin
`ifdef MOFN_SOF_SYNC_EN
            if (s) begin
                mq.delete();
                m_started = 1'b1;
            end
`endif
            if (m_started) begin
                mq.push_back(d);
                if (mq.size() == N) begin
                    ones = 0;
                    for (int i = 0; i < N; i++) begin
                        ones += int'(mq[i]);
                        m_word[N-1-i] = mq[i];
                    end
                    m_done  = 1;
                    m_valid = (ones == M);
                    m_err   = !m_valid;
                    mq.delete();
                end
            end
        end
        if (clr) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else if (m_err) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3)   m_cnt2++;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d t=%0t: got %0h expected %0h", nm, cyc, $time, act, exp);
        end
    endtask

    task automatic chk_model();
        chk("done",       32'(word_done),   32'(m_done));
        chk("valid",      32'(valid),       32'(m_valid));
        chk("err",        32'(err),         32'(m_err));
        chk("word_out",   32'(word_out),    32'(m_word));
        chk("err_count",  32'(err_count),   32'(m_cnt8));
        chk("sat_done",   32'(s_word_done), 32'(m_done));
        chk("sat_valid",  32'(s_valid),     32'(m_valid));
        chk("sat_err",    32'(s_err),       32'(m_err));
        chk("sat_word",   32'(s_word_out),  32'(m_word));
        chk("sat_count",  32'(s_err_count), 32'(m_cnt2));
    endtask

    task automatic step(input logic dv, input logic d, input logic s, input logic clr);
        @(negedge clk);
        din_valid = dv; din = d; sof = s; clr_count = clr;
        @(posedge clk);
        model_edge(dv, d, s, clr);
        #1;
        chk_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetH = 1'b1;
        din_valid = 0; din = 0; sof = 0; clr_count = 0;
        #2;
        model_reset();
        chk("rst_done",  32'(word_done), 0);
        chk("rst_valid", 32'(valid),     0);
        chk("rst_err",   32'(err),       0);
        chk("rst_word",  32'(word_out),  0);
        chk("rst_count", 32'(err_count), 0);
        chk("rst_sat_count", 32'(s_err_count), 0);
        @(negedge clk);
        resetH = 1'b0;
    endtask

    // word of five bits, first bit carries sof, optional clear on the last bit
    task automatic send_word(input logic [4:0] w, input logic clr_last);
        for (int i = 0; i < N; i++)
            step(1'b1, w[N-1-i], (i == 0), clr_last && (i == N-1));
    endtask

    typedef struct {
        logic       dv, d, s, clr;
        logic       done, vld, er;
        logic [4:0] word;
        logic [7:0] cnt;
    } vec_t;

    function automatic vec_t v(input logic dv, input logic d, input logic s, input logic clr,
                               input logic done, input logic vld, input logic er,
                               input logic [4:0] word, input logic [7:0] cnt);
        vec_t r;
        r.dv = dv; r.d = d; r.s = s; r.clr = clr;
        r.done = done; r.vld = vld; r.er = er; r.word = word; r.cnt = cnt;
        return r;
    endfunction

    vec_t tbl[$];
    int   done_cyc[$];

    initial begin
        // 1,0,1,1,0 -> valid
        tbl.push_back(v(1,1,1,0, 0,0,0,5'b00000,0));
        tbl.push_back(v(1,0,0,0, 0,0,0,5'b00000,0));
        tbl.push_back(v(1,1,0,0, 0,0,0,5'b00000,0));
        tbl.push_back(v(1,1,0,0, 0,0,0,5'b00000,0));
        tbl.push_back(v(1,0,0,0, 1,1,0,5'b10110,0));
        // 1,1,1,1,1 -> err, then 0,0,1,1,1 -> valid back-to-back
        tbl.push_back(v(1,1,1,0, 0,0,0,5'b10110,0));
        tbl.push_back(v(1,1,0,0, 0,0,0,5'b10110,0));
        tbl.push_back(v(1,1,0,0, 0,0,0,5'b10110,0));
        tbl.push_back(v(1,1,0,0, 0,0,0,5'b10110,0));
        tbl.push_back(v(1,1,0,0, 1,0,1,5'b11111,1));
        tbl.push_back(v(1,0,1,0, 0,0,0,5'b11111,1));
        tbl.push_back(v(1,0,0,0, 0,0,0,5'b11111,1));
        tbl.push_back(v(1,1,0,0, 0,0,0,5'b11111,1));
        tbl.push_back(v(1,1,0,0, 0,0,0,5'b11111,1));
        tbl.push_back(v(1,1,0,0, 1,1,0,5'b00111,1));
        // 1,0, gap of 3 (din toggling but unqualified), 1,1,0
        tbl.push_back(v(1,1,1,0, 0,0,0,5'b00111,1));
        tbl.push_back(v(1,0,0,0, 0,0,0,5'b00111,1));
        tbl.push_back(v(0,1,0,0, 0,0,0,5'b00111,1));
        tbl.push_back(v(0,0,0,0, 0,0,0,5'b00111,1));
        tbl.push_back(v(0,1,0,0, 0,0,0,5'b00111,1));
        tbl.push_back(v(1,1,0,0, 0,0,0,5'b00111,1));
        tbl.push_back(v(1,1,0,0, 0,0,0,5'b00111,1));
        tbl.push_back(v(1,0,0,0, 1,1,0,5'b10110,1));

        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        foreach (tbl[i]) begin
            step(tbl[i].dv, tbl[i].d, tbl[i].s, tbl[i].clr);
            chk("tbl_done",  32'(word_done), 32'(tbl[i].done));
            chk("tbl_valid", 32'(valid),     32'(tbl[i].vld));
            chk("tbl_err",   32'(err),       32'(tbl[i].er));
            chk("tbl_word",  32'(word_out),  32'(tbl[i].word));
            chk("tbl_count", 32'(err_count), 32'(tbl[i].cnt));
            if (word_done) done_cyc.push_back(cyc);
        end
        if (done_cyc.size() >= 3)
            chk("pulse_spacing", 32'(done_cyc[2] - done_cyc[1]), 32'd5);
        else
            chk("pulse_count", 32'(done_cyc.size()), 32'd3);

        // saturation with CNT_W=2, then clear coinciding with an err word
        do_reset();
        for (int k = 0; k < 4; k++) send_word(5'b11111, 1'b0);
        chk("sat_count3", 32'(s_err_count), 32'd3);
        chk("cnt8_count4", 32'(err_count), 32'd4);
        send_word(5'b11111, 1'b1);
        chk("clr_err_pulse", 32'(err), 32'd1);
        chk("clr_sat_count", 32'(s_err_count), 32'd0);
        chk("clr_count8", 32'(err_count), 32'd0);

        // reset mid-word discards the partial word
        step(1, 1, 1, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        do_reset();
        send_word(5'b01110, 1'b0);
        chk("fresh_valid", 32'(valid), 32'd1);
        chk("fresh_word", 32'(word_out), 32'b01110);

`ifdef MOFN_SOF_SYNC_EN
        begin
            int pulses;
            pulses = 0;
            do_reset();
            step(1, 1, 0, 0); pulses += int'(word_done);
            step(1, 1, 0, 0); pulses += int'(word_done);
            step(1, 1, 1, 0); pulses += int'(word_done);
            step(1, 1, 0, 0); pulses += int'(word_done);
            step(1, 0, 1, 0); pulses += int'(word_done);
            step(1, 1, 0, 0); pulses += int'(word_done);
            step(1, 1, 0, 0); pulses += int'(word_done);
            step(1, 0, 0, 0); pulses += int'(word_done);
            step(1, 1, 0, 0); pulses += int'(word_done);
            chk("sof_pulses", 32'(pulses), 32'd1);
            chk("sof_done", 32'(word_done), 32'd1);
            chk("sof_valid", 32'(valid), 32'd1);
            chk("sof_word", 32'(word_out), 32'b01101);
            chk("sof_count", 32'(err_count), 32'd0);
        end
`endif

        // randomized traffic against the model
        do_reset();
        for (int k = 0; k < 600; k++)
            step(($urandom % 4) != 0, 1'($urandom), ($urandom % 8) == 0, ($urandom % 20) == 0);

        @(negedge clk);
        din_valid = 0; clr_count = 0; sof = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
